// File: rtl/button_event_if.sv
// Groups the debounced button level and the classified event outputs.
// Latency: none. This file only bundles wires.
// Backpressure: none. Every signal is a level or a single-cycle pulse.
interface button_event_if;
  logic       clean;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic [7:0] event_count;
  logic [2:0] state;

  // Driver of the button level and consumer of the events
  modport master (
    output clean,
    input  press_pulse, release_pulse, short_press, long_press,
           double_press, event_count, state
  );

  // Classifier side
  modport slave (
    input  clean,
    output press_pulse, release_pulse, short_press, long_press,
           double_press, event_count, state
  );
endinterface

// File: rtl/button_event.sv
// Classifies a debounced button into press/release, short, long and double events.
// Latency: every output is registered, so a pulse appears one cycle after the edge that samples its cause.
// Backpressure: none. Events are fire-and-forget pulses plus a wrapping 8-bit event counter.
module button_event #(
  parameter int LONG_CNT   = 50000000,
  parameter int DOUBLE_GAP = 15000000
) (
  input logic          clk,
  input logic          reset,
  button_event_if.slave btn
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HELD = 3'd4
  } state_t;

  // The counter holds k-1 at the k-th edge after entering a state, so these
  // terminal values fire exactly LONG_CNT / DOUBLE_GAP edges after entry.
  localparam logic [25:0] LONG_LAST = 26'(LONG_CNT - 1);
  localparam logic [25:0] GAP_LAST  = 26'(DOUBLE_GAP - 1);

  state_t      state_q, state_d;
  logic [25:0] cnt_q, cnt_d;
  logic        clean_d_q, clean_d_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        short_q, short_d;
  logic        long_q, long_d;
  logic        double_q, double_d;
  logic [7:0]  event_count_q, event_count_d;
  logic        rise, fall;

  assign rise = btn.clean & ~clean_d_q;
  assign fall = ~btn.clean & clean_d_q;

  // Next-state, counter, pulse and event-count logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    clean_d_d     = btn.clean;
    press_d       = 1'b0;
    release_d     = 1'b0;
    short_d       = 1'b0;
    long_d        = 1'b0;
    double_d      = 1'b0;
    event_count_d = event_count_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1: begin
        // A release on the terminal edge wins over long detection
        if (fall) begin
          release_d = 1'b1;
          state_d   = WAIT2;
          cnt_d     = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 26'd1;
        end
      end
      WAIT2: begin
        // A repress on the terminal edge still counts as a double
        if (rise) begin
          press_d = 1'b1;
          state_d = PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 26'd1;
        end
      end
      PRESS2: begin
        if (fall) begin
          release_d = 1'b1;
          double_d  = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (short_d | long_d | double_d) begin
      event_count_d = event_count_q + 8'd1;
    end
  end

  // State and output registers; reset tracks clean so a held button is not seen as a press
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      clean_d_q     <= btn.clean;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      short_q       <= 1'b0;
      long_q        <= 1'b0;
      double_q      <= 1'b0;
      event_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      clean_d_q     <= clean_d_d;
      press_q       <= press_d;
      release_q     <= release_d;
      short_q       <= short_d;
      long_q        <= long_d;
      double_q      <= double_d;
      event_count_q <= event_count_d;
    end
  end

  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;
  assign btn.short_press   = short_q;
  assign btn.long_press    = long_q;
  assign btn.double_press  = double_q;
  assign btn.event_count   = event_count_q;
  assign btn.state         = state_q;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_CNT=8 and DOUBLE_GAP=6.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: none. The bench only drives the button level and reset.
module tb_button_event;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   base;
  int   n_press, n_release, n_short, n_long, n_double;
  int   t_press, t_release, t_short, t_long, t_double, f_short;

  button_event_if bif ();

  button_event #(.LONG_CNT(8), .DOUBLE_GAP(6)) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_press = 0; n_release = 0; n_short = 0; n_long = 0; n_double = 0;
    t_press = -1; t_release = -1; t_short = -1; t_long = -1; t_double = -1;
    f_short = -1;
  endtask

  // Advance one cycle and log every pulse with its cycle number
  task automatic tick();
    logic [31:0] nclass;
    @(posedge clk);
    #1;
    cyc++;
    if (bif.press_pulse)   begin n_press++;   t_press   = cyc; end
    if (bif.release_pulse) begin n_release++; t_release = cyc; end
    if (bif.short_press)   begin
      if (n_short == 0) f_short = cyc;
      n_short++; t_short = cyc;
    end
    if (bif.long_press)    begin n_long++;    t_long    = cyc; end
    if (bif.double_press)  begin n_double++;  t_double  = cyc; end
    nclass = 32'(bif.short_press) + 32'(bif.long_press) + 32'(bif.double_press);
    chk("onehot_class", {31'd0, nclass <= 32'd1}, 32'd1);
  endtask

  task automatic drive(input logic v, input int n);
    bif.clean = v;
    repeat (n) tick();
  endtask

  initial begin
    clr();
    bif.clean = 1'b0;
    reset     = 1'b1;
    repeat (3) tick();
    chk("rst_state", bif.state, 0);
    chk("rst_press", bif.press_pulse, 0);
    chk("rst_release", bif.release_pulse, 0);
    chk("rst_short", bif.short_press, 0);
    chk("rst_long", bif.long_press, 0);
    chk("rst_double", bif.double_press, 0);
    chk("rst_evcnt", bif.event_count, 0);
    reset = 1'b0;
    drive(1'b0, 2);

    // Short press: high 3, low 10
    clr(); base = cyc;
    drive(1'b1, 3);
    drive(1'b0, 10);
    chk("short_press_t", t_press - base, 1);
    chk("short_rel_gap", t_release - t_press, 3);
    chk("short_short_gap", t_short - t_release, 6);
    chk("short_n_short", n_short, 1);
    chk("short_n_long", n_long, 0);
    chk("short_n_double", n_double, 0);
    chk("short_evcnt", bif.event_count, 1);
    chk("short_state", bif.state, 0);

    // Long press: high 12, then release
    clr(); base = cyc;
    drive(1'b1, 12);
    chk("long_state_held", bif.state, 4);
    drive(1'b0, 12);
    chk("long_gap", t_long - t_press, 8);
    chk("long_n_long", n_long, 1);
    chk("long_rel_t", t_release - base, 13);
    chk("long_n_short", n_short, 0);
    chk("long_n_double", n_double, 0);
    chk("long_evcnt", bif.event_count, 2);

    // Double press: high 2, low 3, high 2, low
    clr(); base = cyc;
    drive(1'b1, 2);
    drive(1'b0, 3);
    drive(1'b1, 1);
    chk("dbl_state_p2", bif.state, 3);
    drive(1'b1, 1);
    drive(1'b0, 10);
    chk("dbl_n_press", n_press, 2);
    chk("dbl_coincide", t_double, t_release);
    chk("dbl_t", t_double - base, 8);
    chk("dbl_n_double", n_double, 1);
    chk("dbl_n_short", n_short, 0);
    chk("dbl_evcnt", bif.event_count, 3);

    // Repress exactly 6 edges after the fall still counts as double
    clr(); base = cyc;
    drive(1'b1, 2);
    drive(1'b0, 6);
    drive(1'b1, 2);
    drive(1'b0, 10);
    chk("gap6_n_double", n_double, 1);
    chk("gap6_n_short", n_short, 0);
    chk("gap6_evcnt", bif.event_count, 4);

    // Repress 7 edges after the fall: short, then a fresh press
    clr(); base = cyc;
    drive(1'b1, 2);
    drive(1'b0, 7);
    drive(1'b1, 2);
    drive(1'b0, 10);
    chk("gap7_first_short", f_short - base, 9);
    chk("gap7_new_press", t_press - base, 10);
    chk("gap7_n_press", n_press, 2);
    chk("gap7_n_short", n_short, 2);
    chk("gap7_n_double", n_double, 0);
    chk("gap7_evcnt", bif.event_count, 6);

    // Reset mid-hold in PRESS1 with the button kept down
    clr();
    drive(1'b1, 3);
    chk("rmid_state_p1", bif.state, 1);
    reset = 1'b1;
    tick();
    chk("rmid_state_in", bif.state, 0);
    chk("rmid_evcnt_in", bif.event_count, 0);
    tick();
    reset = 1'b0;
    drive(1'b1, 12);
    chk("rmid_n_press", n_press, 1);
    chk("rmid_n_long", n_long, 0);
    chk("rmid_state_held", bif.state, 0);
    drive(1'b0, 3);
    chk("rmid_n_release", n_release, 0);
    chk("rmid_state_low", bif.state, 0);
    drive(1'b1, 1);
    chk("rmid_repress", n_press, 2);
    chk("rmid_state_new", bif.state, 1);
    drive(1'b0, 10);
    chk("rmid_n_short", n_short, 1);
    chk("rmid_evcnt", bif.event_count, 1);

    // Counter wrap over 256 short presses starting from zero
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bif.clean = 1'b0;
    tick();
    clr();
    for (int i = 0; i < 255; i++) begin
      drive(1'b1, 1);
      drive(1'b0, 7);
    end
    chk("wrap_255", bif.event_count, 255);
    drive(1'b1, 1);
    drive(1'b0, 7);
    chk("wrap_0", bif.event_count, 0);
    chk("wrap_n_short", n_short, 256);
    chk("wrap_n_double", n_double, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
